// File: rtl/mem_stream_reader.sv
// mem_stream_reader: read-side engine for a single-clock simple dual-port RAM.
// On an accepted start it reads len consecutive words from base_addr (address wraps) through the
// RAM's 1-cycle registered read port and emits them as an AXI-Stream master with full
// backpressure. Up to 3 reads are outstanding, which the 3-entry skid buffer can always absorb,
// so the stream sustains 1 beat/cycle while m_axis_tready is held high.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             command strobe, accepted only when busy=0
//   base_addr, len    first address and word count (0..2^ADDR_WIDTH), sampled on accept
//   raddr, rdata      RAM read address (registered) and RAM read data
//   m_axis_*          AXI-Stream master (tdata/tvalid/tready/tlast)
//   busy              high from accepted start until the final beat handshakes
//   done              one-cycle pulse after completion (or after a len=0 start)
module mem_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0]   LenOne  = 1;
    localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issue_rem_q;
    logic [ADDR_WIDTH:0]   pop_cnt_q;
    logic [1:0]            outstanding_q;
    logic [1:0]            outstanding_d;
    // Pipeline valid bits: address presented to RAM, then RAM output holding real data.
    logic                  rd_issued_q;
    logic                  rd_data_vld_q;

    logic [DATA_WIDTH-1:0] skid_mem_q [3];
    logic [1:0]            skid_wr_q;
    logic [1:0]            skid_rd_q;
    logic [1:0]            skid_cnt_q;

    logic accept;
    logic start_issue;
    logic issue;
    logic hs;
    logic last_beat;
    logic finish;
    logic push;
    logic pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        accept      = start && !busy_q;
        start_issue = accept && (len != '0);
        hs          = m_axis_tvalid && m_axis_tready;
        last_beat   = (pop_cnt_q == (len_q - LenOne));
        finish      = hs && last_beat;
        // A slot frees up at the same edge as a handshake, so issuing then is still safe.
        issue       = busy_q && (issue_rem_q != '0) && ((outstanding_q != 2'd3) || hs);
        push        = rd_data_vld_q;
        pop         = hs;

        outstanding_d = outstanding_q;
        if ((start_issue || issue) && !hs) begin
            outstanding_d = outstanding_q + 2'd1;
        end else if (!(start_issue || issue) && hs) begin
            outstanding_d = outstanding_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            raddr_q       <= '0;
            len_q         <= '0;
            issue_rem_q   <= '0;
            pop_cnt_q     <= '0;
            outstanding_q <= '0;
            rd_issued_q   <= 1'b0;
            rd_data_vld_q <= 1'b0;
            skid_wr_q     <= '0;
            skid_rd_q     <= '0;
            skid_cnt_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                skid_mem_q[i] <= '0;
            end
        end else begin
            done_q        <= finish || (accept && (len == '0));
            outstanding_q <= outstanding_d;
            rd_issued_q   <= start_issue || issue;
            rd_data_vld_q <= rd_issued_q;

            if (start_issue) begin
                busy_q      <= 1'b1;
                raddr_q     <= base_addr;
                len_q       <= len;
                issue_rem_q <= len - LenOne;
                pop_cnt_q   <= '0;
            end else begin
                if (issue) begin
                    raddr_q     <= raddr_q + AddrOne;
                    issue_rem_q <= issue_rem_q - LenOne;
                end
                if (hs) begin
                    pop_cnt_q <= pop_cnt_q + LenOne;
                end
                if (finish) begin
                    busy_q <= 1'b0;
                end
            end

            if (push) begin
                skid_mem_q[skid_wr_q] <= rdata;
                skid_wr_q             <= next_ptr(skid_wr_q);
            end
            if (pop) begin
                skid_rd_q <= next_ptr(skid_rd_q);
            end
            unique case ({push, pop})
                2'b10:   skid_cnt_q <= skid_cnt_q + 2'd1;
                2'b01:   skid_cnt_q <= skid_cnt_q - 2'd1;
                default: skid_cnt_q <= skid_cnt_q;
            endcase

            skid_overflow: assert (!(push && !pop && (skid_cnt_q == 2'd3)));
        end
    end

    always_comb begin
        raddr         = raddr_q;
        busy          = busy_q;
        done          = done_q;
        m_axis_tvalid = (skid_cnt_q != 2'd0);
        m_axis_tdata  = skid_mem_q[skid_rd_q];
        m_axis_tlast  = m_axis_tvalid && last_beat;
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    mem_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .len           (len),
        .raddr         (raddr),
        .rdata         (rdata),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .busy          (busy),
        .done          (done)
    );

    // RAM with 1-cycle registered read port
    logic [DW-1:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
    always @(posedge clk) rdata <= mem[raddr];

    int n_checks = 0;
    int n_errors = 0;
    int hs_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of the beats each accepted command must produce.
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;
    beat_t         exp_q[$];
    logic          m_busy     = 1'b0;
    logic          exp_done   = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    always @(negedge clk) begin
        logic  next_done;
        logic  was_busy;
        beat_t b;
        if (rst) begin
            exp_q.delete();
            m_busy     = 1'b0;
            exp_done   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            check("busy", busy, m_busy);
            check("done", done, exp_done);
            if (prev_valid && !prev_ready) begin
                check("hold_valid", tvalid, 1);
                check("hold_data", tdata, prev_data);
                check("hold_last", tlast, prev_last);
            end
            was_busy  = m_busy;
            next_done = 1'b0;
            if (tvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_beat: got tdata %0h expected no beat at %0t", tdata, $time);
                end else begin
                    b = exp_q[0];
                    check("tdata", tdata, b.data);
                    check("tlast", tlast, b.last);
                    if (tready) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                        if (b.last) begin
                            m_busy    = 1'b0;
                            next_done = 1'b1;
                        end
                    end
                end
            end else begin
                check("tlast_idle", tlast, 0);
            end
            if (start && !was_busy) begin
                if (len == 0) begin
                    next_done = 1'b1;
                end else begin
                    for (int i = 0; i < int'(len); i++) begin
                        b.data = mem[(int'(base_addr) + i) % 16];
                        b.last = (i == int'(len) - 1);
                        exp_q.push_back(b);
                    end
                    m_busy = 1'b1;
                end
            end
            exp_done   = next_done;
            prev_valid = tvalid;
            prev_ready = tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    // Drives a one-cycle start; returns #1 after the accepting edge.
    task automatic do_start(input int b, input int l);
        start     = 1'b1;
        base_addr = AW'(b);
        len       = (AW + 1)'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: timeout got no done expected done within %0d cycles", name, max_cycles);
    endtask

    initial begin
        int        h0;
        logic [5:0] pat;
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_raddr", raddr, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic: base 2, len 5, tready=1
        do_start(2, 5);
        check("t1_lat_e0", tvalid, 0);
        @(posedge clk); #1;
        check("t1_lat_e1", tvalid, 0);
        @(posedge clk); #1;
        check("t1_first_valid", tvalid, 1);
        check("t1_first_data", tdata, 32'h102);
        check("t1_first_last", tlast, 0);
        repeat (4) @(posedge clk);
        #1;
        check("t1_last_data", tdata, 32'h106);
        check("t1_last_last", tlast, 1);
        @(posedge clk); #1;
        check("t1_done", done, 1);
        check("t1_busy", busy, 0);

        // Wrap: base 14, len 4, started in the done cycle
        do_start(14, 4);
        check("t2_raddr0", raddr, 14);
        @(posedge clk); #1;
        check("t2_raddr1", raddr, 15);
        @(posedge clk); #1;
        check("t2_raddr2", raddr, 0);
        check("t2_first_data", tdata, 32'h10E);
        @(posedge clk); #1;
        check("t2_raddr3", raddr, 1);
        wait_done("t2_done", 20);

        // Toggling backpressure
        pat = 6'b101001;
        do_start(0, 8);
        begin : toggle_loop
            for (int i = 0; i < 80; i++) begin
                tready = pat[i % 6];
                @(posedge clk);
                #1;
                if (done) disable toggle_loop;
            end
            n_checks++;
            n_errors++;
            $display("FAIL t3_done: timeout got no done expected done");
        end
        tready = 1'b1;
        @(posedge clk); #1;

        // Stalled start: only 3 reads issue
        tready = 1'b0;
        do_start(5, 6);
        repeat (10) @(posedge clk);
        #1;
        check("t4_raddr", raddr, 7);
        check("t4_tvalid", tvalid, 1);
        check("t4_tdata", tdata, 32'h105);
        tready = 1'b1;
        wait_done("t4_done", 20);
        @(posedge clk); #1;

        // len=0 then a start ignored while busy
        do_start(9, 0);
        check("t5_done0", done, 1);
        check("t5_valid0", tvalid, 0);
        check("t5_busy0", busy, 0);
        @(posedge clk); #1;
        check("t5_done0_off", done, 0);
        h0 = hs_count;
        do_start(0, 16);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; base_addr = 3; len = 2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t5_done16", 40);
        check("t5_beats", hs_count - h0, 16);
        @(posedge clk); #1;

        // Reset mid-command
        h0 = hs_count;
        do_start(0, 10);
        for (int i = 0; i < 20 && hs_count - h0 < 2; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_tvalid", tvalid, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        @(posedge clk); #1;
        check("t6_tvalid2", tvalid, 0);
        h0 = hs_count;
        do_start(3, 2);
        wait_done("t6_done2", 20);
        check("t6_beats", hs_count - h0, 2);
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
